pooling_layer_max_unit: RTL and testbench
=========================================

Name: pooling_layer_max_unit

Overview:
- Downstream of the pooling-layer input buffer. Consumes the serial IEEE-754 single-precision word stream the buffer shifts out, one word per cycle.
- Reduces each group of WINDOW consecutive valid words to their maximum and emits one registered result per window with a one-cycle valid pulse.
- Feeds the pooling-layer output/write-back stage.

Parameters:
- DATA_WIDTH, 32, word width. Equals `DATA_WIDTH. Bit 31 is sign, 30:23 exponent, 22:0 mantissa.
- WINDOW, 4, words per pooling window (KERNEL_SIZE*KERNEL_SIZE, 2x2). Legal range 2..15.
- CNT_WIDTH, 4, width of the window counter. Must satisfy 2**CNT_WIDTH > WINDOW.

Ports:
- clk, input, 1, clock. All state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous abort of the current partial window.
- data_valid, input, 1, data_in carries a sample this cycle.
- data_in, input, DATA_WIDTH, sample word.
- busy, output, 1, a partial window is held (state ACCUM).
- result_valid, output, 1, one-cycle pulse; result_out and nan_seen are valid this cycle.
- result_out, output, DATA_WIDTH, window maximum.
- nan_seen, output, 1, at least one NaN was present in the reported window.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, cnt=0, running max=0, NaN flag=0.
  - busy=0, result_valid=0, result_out=32'h0, nan_seen=0.
  - Reset mid-window discards the partial window silently.
- FSM states: IDLE (no partial window) and ACCUM (1..WINDOW-1 samples held).
  - IDLE + data_valid: load sample as running max, cnt=1, go to ACCUM. If WINDOW were 1 this would complete the window; WINDOW>=2 is required.
  - ACCUM + data_valid: compare the sample against the running max and keep the winner; cnt=cnt+1.
  - When the accepted sample is the WINDOW-th: next cycle result_out = final max, result_valid=1, nan_seen = window NaN flag; cnt=0; state=IDLE.
  - ACCUM with no data_valid: hold everything. There is no timeout.
- Latency: result_valid is asserted exactly 1 cycle after the clock edge that accepts the last sample of the window.
- Back-to-back windows have no bubble. The sample in the same cycle result_valid is high is the first sample of the next window.
- result_out and nan_seen hold their last values until the next result. result_valid is high for one cycle only.
- Comparison ("candidate b replaces current max a" iff b > a):
  - If the signs differ: the positive operand is greater. +0 (00000000) and -0 (80000000) compare equal.
  - If both are positive: compare bits 30:0 as unsigned; larger is greater.
  - If both are negative: compare bits 30:0 as unsigned; smaller is greater.
  - Ties keep the current max. This applies to -0 versus +0 as well: whichever arrived first is kept.
  - The comparison is combinational on the registered max and data_in. No arithmetic is performed.
- NaN handling (exponent 8'hFF, mantissa != 0):
  - A NaN sample sets the window NaN flag and never replaces a non-NaN max.
  - A non-NaN sample always replaces a NaN max.
  - If every sample in the window is NaN, result_out is the first NaN received.
  - Infinities compare normally.
- clear:
  - Discards the partial window: cnt=0, NaN flag=0, state=IDLE, no result_valid.
  - clear with data_valid in the same cycle: clear wins over the old window, and that sample becomes sample 1 of a new window (state ACCUM, cnt=1).
  - clear in IDLE with no data_valid: no effect.
  - clear does not cancel a result_valid pulse that is already scheduled (the window completed on the previous edge).
- busy = (state == ACCUM).

Test Plan:
1. Reset, then feed 3F800000, 40000000, 3F000000, BF800000 on consecutive cycles -> result_valid pulses 1 cycle after the 4th sample; result_out=40000000; nan_seen=0; busy deasserts.
2. All-negative window C0400000, BF800000, C0000000, C0800000 -> result_out=BF800000 (-1.0). Then 80000000 followed by 00000000, 00000000, 00000000 -> result_out=80000000 (tie keeps first).
3. Two windows back-to-back over 8 cycles: 1,2,3,4 then 5,0.5,0.5,0.5 (in float hex) -> two result_valid pulses 4 cycles apart; results 40800000 then 40A00000.
4. Window 7FC00000, 3F800000, BF800000, 7FC00000 -> result_out=3F800000 with nan_seen=1. Window of four 7FC00001 -> result_out=7FC00001 with nan_seen=1.
5. Feed 2 samples, assert clear alone, then feed 4 samples 3F000000 each -> exactly one result, 3F000000. Repeat with clear coincident with a valid 40400000 followed by three 3F800000 -> result_out=40400000.
6. Gaps in data_valid (idle 3 cycles between samples) and rst_n pulsed low asynchronously mid-window -> all outputs go to 0 immediately; no spurious result_valid; the next full window is reported correctly.

Source files
------------

// File: rtl/pooling_layer_max_unit.sv
// Max-pooling reducer: folds each WINDOW consecutive valid IEEE-754 words into
// their maximum (bitwise ordering, NaN-aware) and emits one registered result.
module pooling_layer_max_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int WINDOW     = 4,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  nan_seen
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(WINDOW - 1);

  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] max_q;
  logic                  nan_q;

  logic                  sample_nan;
  logic                  max_nan;
  logic                  sample_gt;
  logic                  take;
  logic [DATA_WIDTH-1:0] winner;

  assign sample_nan = (&data_in[30:23]) && (|data_in[22:0]);
  assign max_nan    = (&max_q[30:23]) && (|max_q[22:0]);

  // Sign-magnitude ordering on raw bits; +0 and -0 tie so the first one is kept.
  always_comb begin
    sample_gt = 1'b0;
    if (data_in[31] != max_q[31]) begin
      if ((data_in[30:0] != '0) || (max_q[30:0] != '0))
        sample_gt = !data_in[31];
    end else if (!data_in[31]) begin
      sample_gt = data_in[30:0] > max_q[30:0];
    end else begin
      sample_gt = data_in[30:0] < max_q[30:0];
    end
  end

  always_comb begin
    take   = max_nan ? !sample_nan : (!sample_nan && sample_gt);
    winner = take ? data_in : max_q;
  end

  assign busy = (state == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      max_q        <= '0;
      nan_q        <= 1'b0;
      result_valid <= 1'b0;
      result_out   <= '0;
      nan_seen     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      // clear restarts the window; a coincident sample opens the new one.
      if (clear || state == IDLE) begin
        if (data_valid) begin
          max_q <= data_in;
          nan_q <= sample_nan;
          cnt   <= CNT_WIDTH'(1);
          state <= ACCUM;
        end else begin
          cnt   <= '0;
          nan_q <= 1'b0;
          state <= IDLE;
        end
      end else if (data_valid) begin
        if (cnt == LAST) begin
          result_out   <= winner;
          nan_seen     <= nan_q | sample_nan;
          result_valid <= 1'b1;
          max_q        <= winner;
          cnt          <= '0;
          nan_q        <= 1'b0;
          state        <= IDLE;
        end else begin
          max_q <= winner;
          nan_q <= nan_q | sample_nan;
          cnt   <= cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pooling_layer_max_unit.sv
// Bench for pooling_layer_max_unit: directed windows plus random traffic,
// checked every cycle against a queue-based window-maximum model.
module tb_pooling_layer_max_unit;

  localparam int WINDOW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        data_valid;
  logic [31:0] data_in;
  logic        busy;
  logic        result_valid;
  logic [31:0] result_out;
  logic        nan_seen;

  pooling_layer_max_unit #(.DATA_WIDTH(32), .WINDOW(WINDOW), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .data_valid(data_valid),
    .data_in(data_in), .busy(busy), .result_valid(result_valid),
    .result_out(result_out), .nan_seen(nan_seen)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        checking = 1'b0;

  logic [31:0] win[$];
  logic        exp_valid, exp_nan, exp_busy;
  logic [31:0] exp_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 0);
  endfunction

  // Real-number order as a signed integer; both zeros map to 0.
  function automatic longint order_key(input logic [31:0] w);
    longint mag = longint'(w[30:0]);
    return w[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] ref_max(input logic [31:0] q[$]);
    logic [31:0] best;
    bit found = 0;
    foreach (q[i]) begin
      if (!is_nan(q[i]) && (!found || order_key(q[i]) > order_key(best))) begin
        best  = q[i];
        found = 1;
      end
    end
    return found ? best : q[0];
  endfunction

  task automatic model_reset();
    win.delete();
    exp_valid = 0; exp_nan = 0; exp_busy = 0; exp_res = '0;
  endtask

  task automatic model_update(input logic c, input logic v, input logic [31:0] d);
    exp_valid = 0;
    if (c) win.delete();
    if (v) begin
      win.push_back(d);
      if (win.size() == WINDOW) begin
        exp_res   = ref_max(win);
        exp_nan   = 0;
        foreach (win[i]) if (is_nan(win[i])) exp_nan = 1;
        exp_valid = 1;
        win.delete();
      end
    end
    exp_busy = (win.size() != 0);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("result_valid", {31'b0, result_valid}, {31'b0, exp_valid});
      chk("busy",         {31'b0, busy},         {31'b0, exp_busy});
      chk("result_out",   result_out,            exp_res);
      chk("nan_seen",     {31'b0, nan_seen},     {31'b0, exp_nan});
    end
  end

  task automatic step(input logic c, input logic v, input logic [31:0] d);
    clear = c; data_valid = v; data_in = d;
    @(posedge clk);
    model_update(c, v, d);
    #1;
    clear = 0; data_valid = 0;
  endtask

  task automatic feed(input logic [31:0] d);
    step(1'b0, 1'b1, d);
  endtask

  // Pins model and DUT to a hand-computed window result right after completion.
  task automatic pin(input string name, input logic [31:0] res, input logic nan);
    chk({name, "_valid"}, {31'b0, result_valid}, 32'd1);
    chk({name, "_dut"},   result_out, res);
    chk({name, "_model"}, exp_res,    res);
    chk({name, "_nan"},   {31'b0, nan_seen}, {31'b0, nan});
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] pool [8];
    pool = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h80000000,
             32'h7F800000, 32'hFF800000, 32'h40000000, 32'hC0000000};
    case ($urandom_range(0, 5))
      0:       return {1'($urandom), 8'hFF, 23'($urandom) | 23'd1};
      1, 2:    return pool[$urandom_range(0, 7)];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 0; clear = 0; data_valid = 0; data_in = '0;
    model_reset();
    #1;
    chk("reset_busy",  {31'b0, busy},         32'd0);
    chk("reset_valid", {31'b0, result_valid}, 32'd0);
    chk("reset_out",   result_out,            32'd0);
    chk("reset_nan",   {31'b0, nan_seen},     32'd0);
    checking = 1;
    #20 rst_n = 1;
    @(posedge clk); #1;

    // Mixed-sign window
    feed(32'h3F800000); feed(32'h40000000); feed(32'h3F000000); feed(32'hBF800000);
    pin("t1", 32'h40000000, 0);
    step(0, 0, 0);

    // All-negative, then signed-zero tie
    feed(32'hC0400000); feed(32'hBF800000); feed(32'hC0000000); feed(32'hC0800000);
    pin("t2a", 32'hBF800000, 0);
    feed(32'h80000000); feed(32'h00000000); feed(32'h00000000); feed(32'h00000000);
    pin("t2b", 32'h80000000, 0);

    // Back-to-back windows
    feed(32'h3F800000); feed(32'h40000000); feed(32'h40400000); feed(32'h40800000);
    pin("t3a", 32'h40800000, 0);
    feed(32'h40A00000); feed(32'h3F000000); feed(32'h3F000000); feed(32'h3F000000);
    pin("t3b", 32'h40A00000, 0);
    step(0, 0, 0);

    // NaN handling
    feed(32'h7FC00000); feed(32'h3F800000); feed(32'hBF800000); feed(32'h7FC00000);
    pin("t4a", 32'h3F800000, 1);
    feed(32'h7FC00001); feed(32'h7FC00001); feed(32'h7FC00001); feed(32'h7FC00001);
    pin("t4b", 32'h7FC00001, 1);
    step(0, 0, 0);

    // clear alone, then clear with a coincident sample
    feed(32'h40E00000); feed(32'h41000000); step(1, 0, 0);
    feed(32'h3F000000); feed(32'h3F000000); feed(32'h3F000000); feed(32'h3F000000);
    pin("t5a", 32'h3F000000, 0);
    feed(32'h40E00000); feed(32'h41000000); step(1, 1, 32'h40400000);
    feed(32'h3F800000); feed(32'h3F800000); feed(32'h3F800000);
    pin("t5b", 32'h40400000, 0);

    // Gapped input, then async reset mid-window
    feed(32'h3F800000); repeat (3) step(0, 0, 0);
    feed(32'h40000000); repeat (3) step(0, 0, 0);
    rst_n = 0;
    #1;
    chk("areset_busy", {31'b0, busy},   32'd0);
    chk("areset_out",  result_out,      32'd0);
    model_reset();
    #12 rst_n = 1;
    @(posedge clk); #1;
    feed(32'h3F000000); step(0, 0, 0); feed(32'h41200000);
    repeat (3) step(0, 0, 0);
    feed(32'hC1200000); feed(32'h40000000);
    pin("t6", 32'h41200000, 0);

    // Random traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, rand_word());
    end
    step(0, 0, 0);

    @(negedge clk);
    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
